// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx -- serial UART transmitter (transmit half of the UART controller)
//
// Sends one character per accepted `start` strobe: a low start bit, 5..8 data
// bits LSB-first, an optional even/odd parity bit and one or two high stop
// bits, each held for CLKS_PER_BIT clock cycles. Data and frame configuration
// are latched when the frame is accepted, so input changes mid-frame have no
// effect. Optional CTS flow control holds the frame until cts_n is sampled low.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (1..65535)
// Ports
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   start       frame request, sampled only while idle
//   data[7:0]   character to send, bit 0 first
//   amountBits  data bits per frame, clamped into 5..8
//   parity      1 = append a parity bit
//   even        1 = even parity, 0 = odd parity
//   stop        0 = one stop bit, 1 = two stop bits
//   handshake   1 = wait for cts_n low before the start bit
//   cts_n       clear-to-send, active low
//   tx          serial line, idles high (registered)
//   busy        frame pending or in progress (registered)
//   done        one-cycle pulse when the last stop bit has completed
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    input  logic [3:0] amountBits,
    input  logic       parity,
    input  logic       even,
    input  logic       stop,
    input  logic       handshake,
    input  logic       cts_n,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_CTS = 3'd1,
        S_START    = 3'd2,
        S_DATA     = 3'd3,
        S_PARITY   = 3'd4,
        S_STOP     = 3'd5
    } state_t;

    // Index of the last data bit for a requested bit count, clamped to 5..8 bits.
    function automatic logic [2:0] last_index(input logic [3:0] n);
        logic [2:0] idx;
        if (n < 4'd5) begin
            idx = 3'd4;
        end else if (n > 4'd8) begin
            idx = 3'd7;
        end else begin
            idx = 3'(n - 4'd1);
        end
        return idx;
    endfunction

    // Parity over data bits 0..last only; unused upper bits count as zero.
    function automatic logic parity_bit(input logic [7:0] d, input logic [2:0] last,
                                        input logic even_sel);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (3'(i) <= last) begin
                p = p ^ d[i];
            end else begin
                p = p;
            end
        end
        return even_sel ? p : ~p;
    endfunction

    state_t            state_r;
    logic [BAUD_W-1:0] baud_r;
    logic [2:0]        bit_idx_r;
    logic [2:0]        last_idx_r;
    logic [7:0]        data_r;
    logic              par_en_r;
    logic              even_r;
    logic              stop2_r;
    logic              stop_cnt_r;
    logic              tx_r;
    logic              busy_r;
    logic              done_r;

    logic              baud_tc_s;
    logic [2:0]        next_idx_s;

    assign baud_tc_s  = (baud_r == BAUD_LAST);
    assign next_idx_s = bit_idx_r + 3'd1;

    // Frame sequencer; tx/busy/done are registered from the state being entered
    // so they change in the same cycle the state does.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            baud_r     <= '0;
            bit_idx_r  <= 3'd0;
            last_idx_r <= 3'd7;
            data_r     <= 8'd0;
            par_en_r   <= 1'b0;
            even_r     <= 1'b0;
            stop2_r    <= 1'b0;
            stop_cnt_r <= 1'b0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    baud_r     <= '0;
                    bit_idx_r  <= 3'd0;
                    stop_cnt_r <= 1'b0;
                    if (start) begin
                        data_r     <= data;
                        last_idx_r <= last_index(amountBits);
                        par_en_r   <= parity;
                        even_r     <= even;
                        stop2_r    <= stop;
                        busy_r     <= 1'b1;
                        if (handshake) begin
                            state_r <= S_WAIT_CTS;
                            tx_r    <= 1'b1;
                        end else begin
                            state_r <= S_START;
                            tx_r    <= 1'b0;
                        end
                    end else begin
                        tx_r   <= 1'b1;
                        busy_r <= 1'b0;
                    end
                end

                S_WAIT_CTS: begin
                    // No timeout: the frame waits for clear-to-send indefinitely.
                    if (!cts_n) begin
                        state_r <= S_START;
                        tx_r    <= 1'b0;
                    end else begin
                        tx_r <= 1'b1;
                    end
                end

                S_START: begin
                    if (baud_tc_s) begin
                        baud_r    <= '0;
                        bit_idx_r <= 3'd0;
                        state_r   <= S_DATA;
                        tx_r      <= data_r[0];
                    end else begin
                        baud_r <= baud_r + BAUD_ONE;
                    end
                end

                S_DATA: begin
                    if (baud_tc_s) begin
                        baud_r <= '0;
                        if (bit_idx_r == last_idx_r) begin
                            if (par_en_r) begin
                                state_r <= S_PARITY;
                                tx_r    <= parity_bit(data_r, last_idx_r, even_r);
                            end else begin
                                state_r    <= S_STOP;
                                stop_cnt_r <= 1'b0;
                                tx_r       <= 1'b1;
                            end
                        end else begin
                            bit_idx_r <= next_idx_s;
                            tx_r      <= data_r[next_idx_s];
                        end
                    end else begin
                        baud_r <= baud_r + BAUD_ONE;
                    end
                end

                S_PARITY: begin
                    if (baud_tc_s) begin
                        baud_r     <= '0;
                        state_r    <= S_STOP;
                        stop_cnt_r <= 1'b0;
                        tx_r       <= 1'b1;
                    end else begin
                        baud_r <= baud_r + BAUD_ONE;
                    end
                end

                S_STOP: begin
                    if (baud_tc_s) begin
                        baud_r <= '0;
                        if (stop2_r && !stop_cnt_r) begin
                            stop_cnt_r <= 1'b1;
                        end else begin
                            state_r <= S_IDLE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        baud_r <= baud_r + BAUD_ONE;
                    end
                    tx_r <= 1'b1;
                end

                default: begin
                    state_r <= S_IDLE;
                    baud_r  <= '0;
                    tx_r    <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign tx   = tx_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx -- directed self-checking bench for uart_tx.
// Two instances: dut1 with CLKS_PER_BIT = 1 and dut4 with CLKS_PER_BIT = 4.
// Inputs change 1 time unit after a rising edge; outputs are observed there,
// so an observation right after edge k reflects the registers loaded at k.
// Expected frames are hand-written bit strings, index 0 = first bit on tx.
// ---------------------------------------------------------------------------
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       start1;
    logic       start4;
    logic [7:0] data;
    logic [3:0] amountBits;
    logic       parity;
    logic       even;
    logic       stop;
    logic       handshake;
    logic       cts_n;
    logic       tx1, busy1, done1;
    logic       tx4, busy4, done4;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .data(data), .amountBits(amountBits),
        .parity(parity), .even(even), .stop(stop), .handshake(handshake),
        .cts_n(cts_n), .tx(tx1), .busy(busy1), .done(done1)
    );

    uart_tx #(.CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .data(data), .amountBits(amountBits),
        .parity(parity), .even(even), .stop(stop), .handshake(handshake),
        .cts_n(cts_n), .tx(tx4), .busy(busy4), .done(done4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic config_frame(input logic [7:0] d, input logic [3:0] n, input logic p,
                                input logic e, input logic s);
        data       = d;
        amountBits = n;
        parity     = p;
        even       = e;
        stop       = s;
    endtask

    // Called in the cycle right after the accepting edge; walks n bit periods
    // of dut1 and ends in the expected done cycle.
    task automatic run_frame1(input string tag, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s tx bit%0d", tag, i), tx1, bits[i]);
            chk($sformatf("%s busy bit%0d", tag, i), busy1, 1'b1);
            chk($sformatf("%s done bit%0d", tag, i), done1, 1'b0);
            tick();
        end
        chk({tag, " done pulse"}, done1, 1'b1);
        chk({tag, " busy end"}, busy1, 1'b0);
        chk({tag, " tx end"}, tx1, 1'b1);
    endtask

    initial begin
        rst       = 1'b1;
        start1    = 1'b0;
        start4    = 1'b0;
        handshake = 1'b0;
        cts_n     = 1'b1;
        config_frame(8'h00, 4'd8, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk("reset tx1", tx1, 1'b1);
        chk("reset busy1", busy1, 1'b0);
        chk("reset done1", done1, 1'b0);
        chk("reset tx4", tx4, 1'b1);
        chk("reset busy4", busy4, 1'b0);
        rst = 1'b0;
        tick();

        // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1
        config_frame(8'hA5, 4'd8, 1'b0, 1'b0, 1'b0);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        run_frame1("8N1_A5", 16'b0000_0011_0100_1010, 10);
        tick();
        chk("8N1 idle after done", done1, 1'b0);

        // 7E2 0x41: 0, 1000001, parity 0, 1,1
        config_frame(8'h41, 4'd7, 1'b1, 1'b1, 1'b1);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        run_frame1("7E2_41", 16'b0000_0110_1000_0010, 11);
        tick();

        // 7O2 0x41: parity bit becomes 1
        config_frame(8'h41, 4'd7, 1'b1, 1'b0, 1'b1);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        run_frame1("7O2_41", 16'b0000_0111_1000_0010, 11);
        tick();

        // amountBits = 15 clamps to 8; 0x80 odd parity -> parity bit 0
        config_frame(8'h80, 4'd15, 1'b1, 1'b0, 1'b0);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        run_frame1("clamp_hi_80", 16'b0000_0101_0000_0000, 11);
        tick();

        // amountBits = 0 clamps to 5; upper ones of 0xFF never appear
        config_frame(8'hFF, 4'd0, 1'b0, 1'b0, 1'b0);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        run_frame1("clamp_lo_FF", 16'b0000_0000_0111_1110, 7);
        tick();

        // CLKS_PER_BIT = 4, 5N1 0x1F: each bit held 4 cycles, done at k+1+28
        config_frame(8'h1F, 4'd5, 1'b0, 1'b0, 1'b0);
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        begin
            logic [6:0] bits4;
            bits4 = 7'b1111110;
            for (int i = 0; i < 28; i++) begin
                chk($sformatf("cpb4 tx cyc%0d", i), tx4, bits4[i / 4]);
                chk($sformatf("cpb4 busy cyc%0d", i), busy4, 1'b1);
                chk($sformatf("cpb4 done cyc%0d", i), done4, 1'b0);
                tick();
            end
        end
        chk("cpb4 done pulse", done4, 1'b1);
        chk("cpb4 busy end", busy4, 1'b0);
        chk("cpb4 tx end", tx4, 1'b1);
        tick();

        // Handshake: wait 20 cycles on cts_n = 1, then a single low sample
        config_frame(8'hA5, 4'd8, 1'b0, 1'b0, 1'b0);
        handshake = 1'b1;
        cts_n     = 1'b1;
        start1    = 1'b1;
        tick();
        start1 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("cts wait tx cyc%0d", i), tx1, 1'b1);
            chk($sformatf("cts wait busy cyc%0d", i), busy1, 1'b1);
            tick();
        end
        cts_n = 1'b0;
        tick();
        cts_n = 1'b1;   // rises during the frame; must not pause it
        run_frame1("cts_A5", 16'b0000_0011_0100_1010, 10);
        handshake = 1'b0;
        tick();

        // Back-to-back: start held high; the done cycle accepts the next frame
        config_frame(8'hA5, 4'd8, 1'b0, 1'b0, 1'b0);
        start1 = 1'b1;
        tick();
        run_frame1("b2b_f1", 16'b0000_0011_0100_1010, 10);
        tick();
        run_frame1("b2b_f2", 16'b0000_0011_0100_1010, 10);
        start1 = 1'b0;
        tick();
        chk("b2b idle tx", tx1, 1'b1);
        chk("b2b idle busy", busy1, 1'b0);

        // Reset mid-frame, with start asserted in the reset cycle
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (4) tick();
        chk("midrst busy before", busy1, 1'b1);
        rst    = 1'b1;
        start1 = 1'b1;
        tick();
        chk("midrst tx", tx1, 1'b1);
        chk("midrst busy", busy1, 1'b0);
        chk("midrst done", done1, 1'b0);
        rst    = 1'b0;
        start1 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("postrst done cyc%0d", i), done1, 1'b0);
            chk($sformatf("postrst busy cyc%0d", i), busy1, 1'b0);
        end
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        run_frame1("postrst_A5", 16'b0000_0011_0100_1010, 10);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
